// File: rtl/iot_riscv_busarb_if.sv
// rtl/iot_riscv_busarb_if.sv - fetch, LSU and system-bus signal bundle for the bus arbiter
interface iot_riscv_busarb_if;
  logic        i_rd_i;
  logic [31:0] i_addr_i;
  logic        i_grant_o;
  logic        i_rdy_o;
  logic [31:0] i_rdata_o;

  logic        d_rd_i;
  logic        d_wr_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [1:0]  d_size_i;
  logic        d_grant_o;
  logic        d_rdy_o;
  logic [31:0] d_rdata_o;

  logic        bus_rd_o;
  logic        bus_wr_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [1:0]  bus_size_o;
  logic        bus_grant_i;
  logic        bus_rdy_i;
  logic [31:0] bus_rdata_i;

  modport slave (
    input  i_rd_i, i_addr_i,
    output i_grant_o, i_rdy_o, i_rdata_o,
    input  d_rd_i, d_wr_i, d_addr_i, d_wdata_i, d_size_i,
    output d_grant_o, d_rdy_o, d_rdata_o,
    output bus_rd_o, bus_wr_o, bus_addr_o, bus_wdata_o, bus_size_o,
    input  bus_grant_i, bus_rdy_i, bus_rdata_i
  );

  modport master (
    output i_rd_i, i_addr_i,
    input  i_grant_o, i_rdy_o, i_rdata_o,
    output d_rd_i, d_wr_i, d_addr_i, d_wdata_i, d_size_i,
    input  d_grant_o, d_rdy_o, d_rdata_o,
    input  bus_rd_o, bus_wr_o, bus_addr_o, bus_wdata_o, bus_size_o,
    output bus_grant_i, bus_rdy_i, bus_rdata_i
  );
endinterface

// File: rtl/iot_riscv_busarb.sv
// rtl/iot_riscv_busarb.sv - fetch/LSU arbiter for the single core memory bus
// Optional round-robin selection via IOT_RISCV_BUSARB_RR_EN (default: D over I).
module iot_riscv_busarb (
  input logic                  main_clk_i,
  input logic                  main_rst_an_i,
  iot_riscv_busarb_if.slave    bus_if
);

  typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} owner_e;
  typedef enum logic [1:0] {REQ_NONE, REQ_I, REQ_D} req_e;

  owner_e owner_r, owner_nxt;
  req_e   lock_r, lock_nxt;
  req_e   prio, sel;
  logic   i_req, d_req, addr_ok, grant;

  assign i_req   = bus_if.i_rd_i;
  assign d_req   = bus_if.d_rd_i | bus_if.d_wr_i;
  // A completing data phase frees the bus for a new address phase in the same cycle.
  assign addr_ok = (owner_r == IDLE) | bus_if.bus_rdy_i;

`ifdef IOT_RISCV_BUSARB_RR_EN
  req_e last_r, last_nxt;

  always_comb begin
    prio = REQ_NONE;
    if (d_req && i_req) prio = (last_r == REQ_D) ? REQ_I : REQ_D;
    else if (d_req)     prio = REQ_D;
    else if (i_req)     prio = REQ_I;
  end

  always_comb begin
    last_nxt = last_r;
    if (grant) last_nxt = sel;
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) last_r <= REQ_I;
    else                last_r <= last_nxt;
  end
`else
  always_comb begin
    prio = REQ_NONE;
    if (d_req)      prio = REQ_D;
    else if (i_req) prio = REQ_I;
  end
`endif

  always_comb begin
    sel = REQ_NONE;
    if (addr_ok) begin
      if (lock_r == REQ_I && i_req)      sel = REQ_I;
      else if (lock_r == REQ_D && d_req) sel = REQ_D;
      else                               sel = prio;
    end
  end

  assign grant = (sel != REQ_NONE) & bus_if.bus_grant_i;

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      owner_r <= IDLE;
      lock_r  <= REQ_NONE;
    end else begin
      owner_r <= owner_nxt;
      lock_r  <= lock_nxt;
    end
  end

  // An ungranted selection pins the requester; a dropped request falls back to NONE.
  always_comb begin
    owner_nxt = owner_r;
    lock_nxt  = grant ? REQ_NONE : sel;
    if (grant)                 owner_nxt = (sel == REQ_I) ? OWN_I : OWN_D;
    else if (bus_if.bus_rdy_i) owner_nxt = IDLE;
  end

  always_comb begin
    bus_if.bus_rd_o    = 1'b0;
    bus_if.bus_wr_o    = 1'b0;
    bus_if.bus_addr_o  = 32'h0;
    bus_if.bus_wdata_o = 32'h0;
    bus_if.bus_size_o  = 2'd0;
    case (sel)
      REQ_I: begin
        bus_if.bus_rd_o   = 1'b1;
        bus_if.bus_addr_o = bus_if.i_addr_i;
        bus_if.bus_size_o = 2'd2;
      end
      REQ_D: begin
        bus_if.bus_rd_o    = bus_if.d_rd_i;
        bus_if.bus_wr_o    = bus_if.d_wr_i;
        bus_if.bus_addr_o  = bus_if.d_addr_i;
        bus_if.bus_wdata_o = bus_if.d_wdata_i;
        bus_if.bus_size_o  = bus_if.d_size_i;
      end
      default: ;
    endcase
    bus_if.i_grant_o = (sel == REQ_I) & bus_if.bus_grant_i;
    bus_if.d_grant_o = (sel == REQ_D) & bus_if.bus_grant_i;
    bus_if.i_rdy_o   = bus_if.bus_rdy_i & (owner_r == OWN_I);
    bus_if.d_rdy_o   = bus_if.bus_rdy_i & (owner_r == OWN_D);
    bus_if.i_rdata_o = (owner_r == OWN_I) ? bus_if.bus_rdata_i : 32'h0;
    bus_if.d_rdata_o = (owner_r == OWN_D) ? bus_if.bus_rdata_i : 32'h0;
  end

  a_no_orphan_rdy: assert property (@(posedge main_clk_i) disable iff (!main_rst_an_i)
    !(bus_if.bus_rdy_i && owner_r == IDLE));

endmodule
